// File: rtl/serial_frame_tx_if.sv
// Parallel-side handshake of the serial frame transmitter: a word plus
// valid from the producer, and ready back from the transmitter.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid;
    logic              ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: accepts a DATA_W-bit word on a valid/ready
// handshake and sends start bit, data LSB first, optional even parity and
// stop bit, each bit held for CLKS_PER_BIT clocks. The line idles high.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_frame_tx_if.slave       link,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              par, par_nxt;
    logic              tx_nxt;
    logic              done_nxt;
    logic              div_last;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign div_last   = (div == DIV_LAST);
    assign link.ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // State, divider, shift register and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            par     <= par_nxt;
            tx      <= tx_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state logic: each bit advances only at divider terminal count.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        par_nxt   = par;
        tx_nxt    = tx;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                div_nxt = '0;
                if (link.valid) begin
                    shift_nxt = link.data_in;
                    par_nxt   = even_parity(link.data_in);
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (div_last) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                    shift_nxt = shift >> 1;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (div_last) begin
                    if (bit_cnt == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        tx_nxt    = shift[0];
                        shift_nxt = shift >> 1;
                        bit_nxt   = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (div_last) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (div_last) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase

        // The divider wraps at terminal count so every bit lasts CLKS_PER_BIT clocks.
        if (state != IDLE) begin
            div_nxt = div_last ? '0 : div + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (default timing with parity, and
// one bit per clock without parity) checked every cycle against a frame-level
// model, plus literal bit patterns for the directed frames.
module tb_serial_frame_tx;

    localparam int CPB_A = 4;
    localparam int FA    = 11;
    localparam int CPB_B = 1;
    localparam int FB    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_tx, a_busy, a_done;
    logic b_tx, b_busy, b_done;

    int n_cmp = 0;
    int n_bad = 0;

    serial_frame_tx_if #(.DATA_W(8)) a_if ();
    serial_frame_tx_if #(.DATA_W(8)) b_if ();

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB_A), .PARITY_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .link(a_if), .tx(a_tx), .busy(a_busy), .done(a_done)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB_B), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .link(b_if), .tx(b_tx), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    // Frame model: which line level belongs to cycle 'cyc' of a frame carrying w.
    function automatic logic frame_bit(input logic [7:0] w, input int cyc,
                                       input int cpb, input int pe);
        int idx;
        idx = cyc / cpb;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (pe != 0 && idx == 9) return ^w;
        return 1'b1;
    endfunction

    bit       ma_act, ma_done, mb_act, mb_done;
    int       ma_cnt, mb_cnt;
    logic [7:0] ma_word, mb_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_act = 0; ma_done = 0; ma_cnt = 0; ma_word = '0;
        end else begin
            ma_done = 0;
            if (ma_act) begin
                ma_cnt++;
                if (ma_cnt == FA * CPB_A) begin ma_act = 0; ma_done = 1; end
            end else if (a_if.valid) begin
                ma_act = 1; ma_cnt = 0; ma_word = a_if.data_in;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_act = 0; mb_done = 0; mb_cnt = 0; mb_word = '0;
        end else begin
            mb_done = 0;
            if (mb_act) begin
                mb_cnt++;
                if (mb_cnt == FB * CPB_B) begin mb_act = 0; mb_done = 1; end
            end else if (b_if.valid) begin
                mb_act = 1; mb_cnt = 0; mb_word = b_if.data_in;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("a_tx", int'(a_tx), ma_act ? int'(frame_bit(ma_word, ma_cnt, CPB_A, 1)) : 1);
        check("a_ready", int'(a_if.ready), int'(!ma_act));
        check("a_busy", int'(a_busy), int'(ma_act));
        check("a_done", int'(a_done), int'(ma_done));
        check("b_tx", int'(b_tx), mb_act ? int'(frame_bit(mb_word, mb_cnt, CPB_B, 0)) : 1);
        check("b_ready", int'(b_if.ready), int'(!mb_act));
        check("b_busy", int'(b_busy), int'(mb_act));
        check("b_done", int'(b_done), int'(mb_done));
    end

    task automatic send_a(input logic [7:0] w);
        @(negedge clk);
        a_if.valid = 1'b1;
        a_if.data_in = w;
        @(posedge clk); #1;
        a_if.valid = 1'b0;
    endtask

    // Samples the first cycle of each bit, starting at the accept edge + 1.
    task automatic capture_a(output logic [15:0] bits);
        bits = '0;
        for (int i = 0; i < FA; i++) begin
            bits[i] = a_tx;
            repeat (CPB_A) @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] bits, bits2;

    initial begin
        a_if.valid = 1'b0; a_if.data_in = '0;
        b_if.valid = 1'b0; b_if.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(a_tx), 1);
        check("rst_ready", int'(a_if.ready), 1);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Model pins
        check("model_par_a5", int'(frame_bit(8'hA5, 36, CPB_A, 1)), 0);
        check("model_par_01", int'(frame_bit(8'h01, 36, CPB_A, 1)), 1);
        check("model_b_stop", int'(frame_bit(8'h80, 8, CPB_B, 0)), 1);

        // 0xA5: 0,1,0,1,0,0,1,0,1, parity 0, stop 1; done 44 cycles after accept
        send_a(8'hA5);
        capture_a(bits);
        check("a5_bits", int'(bits[10:0]), 'h54A);
        check("a5_done44", int'(a_done), 1);
        check("a5_ready44", int'(a_if.ready), 1);
        repeat (3) @(posedge clk);

        // Back-to-back 0x01 then 0xFF with valid held high
        @(negedge clk);
        a_if.valid = 1'b1; a_if.data_in = 8'h01;
        @(posedge clk); #1;
        a_if.data_in = 8'hFF;
        capture_a(bits);
        check("b2b_01_bits", int'(bits[10:0]), 'h602);
        check("b2b_idle_tx", int'(a_tx), 1);
        check("b2b_idle_done", int'(a_done), 1);
        @(posedge clk); #1;
        a_if.valid = 1'b0;
        check("b2b_start45", int'(a_tx), 0);
        check("b2b_ready45", int'(a_if.ready), 0);
        capture_a(bits2);
        check("b2b_ff_bits", int'(bits2[10:0]), 'h5FE);
        check("b2b_ff_done", int'(a_done), 1);
        repeat (3) @(posedge clk);

        // valid pulse with 0x3C mid-frame is ignored
        send_a(8'hC3);
        fork
            capture_a(bits);
            begin
                repeat (10) @(negedge clk);
                a_if.valid = 1'b1; a_if.data_in = 8'h3C;
                @(negedge clk);
                a_if.valid = 1'b0;
            end
        join
        check("ign_bits", int'(bits[10:0]), 'h586);
        check("ign_done", int'(a_done), 1);
        repeat (10) @(posedge clk);
        #1;
        check("ign_no_frame_ready", int'(a_if.ready), 1);
        check("ign_no_frame_tx", int'(a_tx), 1);

        // data_in change after accept has no effect
        send_a(8'h55);
        a_if.data_in = 8'hAA;
        capture_a(bits);
        check("hold_bits", int'(bits[10:0]), 'h4AA);
        repeat (3) @(posedge clk);

        // Asynchronous reset during data bit 1 (a zero) of 0xA5
        send_a(8'hA5);
        repeat (8) @(posedge clk);
        #2;
        check("prerst_tx", int'(a_tx), 0);
        rst_n = 1'b0;
        #1;
        check("arst_tx", int'(a_tx), 1);
        check("arst_ready", int'(a_if.ready), 1);
        check("arst_busy", int'(a_busy), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("postrst_idle_tx", int'(a_tx), 1);
        check("postrst_ready", int'(a_if.ready), 1);
        send_a(8'h01);
        capture_a(bits);
        check("postrst_bits", int'(bits[10:0]), 'h602);
        repeat (3) @(posedge clk);

        // One bit per clock, no parity: 0x80 -> 0,0,0,0,0,0,0,0,1,1
        @(negedge clk);
        b_if.valid = 1'b1; b_if.data_in = 8'h80;
        @(posedge clk); #1;
        b_if.valid = 1'b0;
        bits = '0;
        for (int i = 0; i < FB; i++) begin
            bits[i] = b_tx;
            @(posedge clk); #1;
        end
        check("b80_bits", int'(bits[9:0]), 'h300);
        check("b80_done10", int'(b_done), 1);
        repeat (5) @(posedge clk);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmitter end of the team's single-wire serial frame link: parallel word in, framed bit stream out.
- Converts a DATA_W-bit word, accepted on a valid/ready handshake, into a framed serial stream: start bit, data LSB first, optional even parity, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Drives the serial input of the FSM-based frame receivers and detectors in the fsm_verilog library, and is the stimulus source for their benches.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).
- PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- data_in  input  DATA_W  word to transmit; sampled only on an accepting edge.
- valid  input  1  data_in holds a word to send.
- ready  output  1  transmitter is idle and will accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (= ~ready).
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, tx=1, ready=1, busy=0, done=0.
  - Bit counter, clock divider and shift register all cleared.
  - Reset mid-frame aborts the frame immediately: tx returns high with no glitch low. No resumption after deassert.
- States: IDLE, START, DATA, PARITY, STOP.
- ready is a decode of state==IDLE. tx and done are registered.
- Accept: at a posedge with state==IDLE and valid==1:
  - latch data_in into the shift register;
  - compute parity = XOR of data_in;
  - state->START, tx<=0, divider<=0.
  - valid while not IDLE is ignored. data_in changes after acceptance have no effect.
- Bit timing: the divider counts 0..CLKS_PER_BIT-1. At terminal count the next bit is loaded onto tx and the divider wraps to 0. Every bit is exactly CLKS_PER_BIT cycles.
- START -> DATA: tx = shift[0]. Shift right once per bit; bit counter counts 0..DATA_W-1.
- DATA -> PARITY (PARITY_EN=1) with tx=parity, or DATA -> STOP (PARITY_EN=0) with tx=1.
- PARITY -> STOP: tx=1.
- STOP -> IDLE at terminal count: tx stays 1, done<=1 for exactly one cycle.
- Frame length F = 2 + DATA_W + PARITY_EN bits. If accepted at edge N, tx is low from edge N and the state returns to IDLE at edge N + F*CLKS_PER_BIT.
- Back-to-back:
  - valid held high is accepted again at the first edge after IDLE is re-entered (done cycle).
  - Minimum frame period is F*CLKS_PER_BIT + 1 cycles.
  - The line stays high for exactly 1 idle cycle between frames.
- Parity is even: count of ones over data+parity is even.
- CLKS_PER_BIT=1: the divider is always at terminal count; one bit per clock, same state sequence.

Test Plan:
- Defaults (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1), send 0xA5 -> tx shows 0 (4 clk), bits 1,0,1,0,0,1,0,1 (4 clk each), parity 0, stop 1. done pulses at cycle 44 after accept. ready low for 44 cycles.
- Send 0x01 then 0xFF, valid held high -> parity bits 1 then 0. Second start bit begins exactly 45 cycles after the first. Exactly one high idle cycle between frames.
- Pulse valid with 0x3C during a frame in progress -> ignored. tx sequence identical to an undisturbed frame. No second frame is sent.
- Change data_in from 0x55 to 0xAA one cycle after accept -> 0x55 is transmitted.
- Assert rst_n low mid-data-bit (tx=0) -> tx=1 and ready=1 immediately (asynchronous). After release, no further frame bits; the next accepted word transmits normally.
- CLKS_PER_BIT=1, PARITY_EN=0, send 0x80 -> tx: 0,0,0,0,0,0,0,0,1,1. done asserted 10 cycles after accept.
